// File: rtl/shift_pkg.sv
// Shared definitions for the two-stage shift unit.
//   shift_mode_e : operation encodings carried on in_mode
//   STAGE_SPLIT  : divisor that sets how many low shamt bits the first stage
//                  consumes (SHW / STAGE_SPLIT); the second stage takes the rest
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } shift_mode_e;

  localparam int STAGE_SPLIT = 2;

endpackage

// File: rtl/shift_stage.sv
// Combinational partial shifter. Shifts data by (amt << OFFSET) positions in
// the selected mode and reports whether any 1 bit fell off the end.
//   data   : operand
//   amt    : the slice of the shift amount this stage is responsible for
//   mode   : SLL / SRL / SRA / ROL
//   res    : shifted data
//   flag   : OR of the bits shifted out (always 0 for ROL)
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int AW     = 1,
  parameter int OFFSET = 0
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    amt,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] res,
  output logic             flag
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]        s;
  logic [2*WIDTH-1:0]   wide;

  // A double-width shift keeps the lost bits in the spare half, so the flag is
  // just an OR over that half. For SRA the MSB at this point is still the
  // original MSB, because any earlier stage filled with copies of it.
  always_comb begin
    s    = SW'(amt) << OFFSET;
    wide = '0;
    res  = data;
    flag = 1'b0;
    case (mode)
      MODE_SLL: begin
        wide = {{WIDTH{1'b0}}, data} << s;
        res  = wide[WIDTH-1:0];
        flag = |wide[2*WIDTH-1:WIDTH];
      end
      MODE_SRL: begin
        wide = {data, {WIDTH{1'b0}}} >> s;
        res  = wide[2*WIDTH-1:WIDTH];
        flag = |wide[WIDTH-1:0];
      end
      MODE_SRA: begin
        wide = $signed({data, {WIDTH{1'b0}}}) >>> s;
        res  = wide[2*WIDTH-1:WIDTH];
        flag = |wide[WIDTH-1:0];
      end
      MODE_ROL: begin
        wide = {data, data} << s;
        res  = wide[2*WIDTH-1:WIDTH];
        flag = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Two-stage pipelined barrel shifter with valid/ready handshakes.
// Stage 1 applies the low shamt bits, stage 2 the remaining high bits; the
// partial flag from stage 1 rides along and is ORed into the final flag.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake
//   in_data, in_shamt   : operand and shift amount (0..WIDTH-1)
//   in_mode             : 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid/out_ready : result handshake
//   out_data, out_flag  : shifted result and shifted-out indicator
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flag
);

  localparam int LO = SHW / STAGE_SPLIT;
  localparam int HI = SHW - LO;

  logic              s1_valid;
  logic [WIDTH-1:0]  s1_data;
  logic              s1_flag;
  shift_mode_e       s1_mode;
  logic [HI-1:0]     s1_shamt_hi;

  logic              s2_valid;
  logic [WIDTH-1:0]  s2_data;
  logic              s2_flag;

  logic              s1_adv;
  logic              s2_adv;
  logic [WIDTH-1:0]  st1_res;
  logic              st1_flag;
  logic [WIDTH-1:0]  st2_res;
  logic              st2_flag;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s2_adv || !s1_valid;
  assign in_ready = !s1_valid || s1_adv;

  shift_stage #(.WIDTH(WIDTH), .AW(LO), .OFFSET(0)) u_stage1 (
    .data (in_data),
    .amt  (in_shamt[LO-1:0]),
    .mode (shift_mode_e'(in_mode)),
    .res  (st1_res),
    .flag (st1_flag)
  );

  shift_stage #(.WIDTH(WIDTH), .AW(HI), .OFFSET(LO)) u_stage2 (
    .data (s1_data),
    .amt  (s1_shamt_hi),
    .mode (s1_mode),
    .res  (st2_res),
    .flag (st2_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_flag     <= 1'b0;
      s1_mode     <= MODE_SLL;
      s1_shamt_hi <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data     <= st1_res;
        s1_flag     <= st1_flag;
        s1_mode     <= shift_mode_e'(in_mode);
        s1_shamt_hi <= in_shamt[SHW-1:LO];
      end
    end
  end

  // S2 only loads when it advances, which keeps the output stable under
  // backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_flag  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= st2_res;
        s2_flag <= s1_flag | st2_flag;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_flag  = s2_flag;

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter: WIDTH, default 8, data width; power of two, 4..64.
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: in_valid  input  1  input operand valid.
REQ-006 Port: in_ready  output  1  unit accepts operand this cycle.
REQ-007 Port: in_data  input  WIDTH  operand.
REQ-008 Port: in_shamt  input  SHW  shift amount, 0..WIDTH-1.
REQ-009 Port: in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 Port: out_valid  output  1  result valid.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: out_data  output  WIDTH  shifted result.
REQ-013 Port: out_flag  output  1  shifted-out indicator.

Function
REQ-014 Transfer occurs on a rising edge with valid and ready both high, on either side.
REQ-015 Two register stages S1, S2, each with a valid bit; latency 2 cycles from input transfer to out_valid, throughput one result per cycle.
REQ-016 S2 advances when !S2.valid or out_ready; S1 advances when S2 advances or S1 is empty; in_ready = !S1.valid or S1 advances.
REQ-017 S1 applies shamt bits [SHW/2-1:0]; S2 applies the remaining upper bits, using the mode and upper shamt bits carried in S1.
REQ-018 SLL: zeros fill the LSBs; out_flag = 1 if any 1 bit is shifted out past the MSB.
REQ-019 SRL: zeros fill the MSBs; out_flag = OR of all bits shifted out past the LSB (sticky).
REQ-020 SRA: copies of the original MSB fill the MSBs; out_flag as in SRL.
REQ-021 ROL: bits leaving the MSB re-enter at the LSB; out_flag = 0.
REQ-022 shamt = 0 passes the data unchanged with out_flag = 0, in every mode.
REQ-023 The S1 partial flag is carried in S1 and ORed with the S2 flag; no flag is dropped between stages.
REQ-024 While out_valid is high and out_ready is low, out_data and out_flag hold stable.
REQ-025 Accepting an operand into S1 while S2 drains in the same cycle does not lose or duplicate results.
REQ-026 in_valid is ignored while in_ready is low; the caller holds its operand.

Reset
REQ-027 When rst_n is asserted: S1.valid = S2.valid = 0, out_valid = 0, out_data = 0, out_flag = 0; in_ready = 1 from the first edge after deassertion.
REQ-028 Reset mid-operation discards all in-flight operands; no partial result appears after release.

Structure
REQ-029 Package shift_pkg holds the mode encodings (SLL, SRL, SRA, ROL) and the stage-split constant.
REQ-030 Sub-module shift_stage: combinational partial shifter (data, amount bits, bit offset, mode -> data, flag), instantiated once per stage.

Verification
REQ-031 Bench (WIDTH=8): SLL 0x96 shamt 3 -> out_data 0xB0, out_flag 1, out_valid exactly 2 cycles after the input transfer.
REQ-032 SRA 0x96 shamt 2 -> 0xE5, flag 1; SRL 0x80 shamt 7 -> 0x01, flag 0.
REQ-033 ROL 0x96 shamt 4 -> 0x69, flag 0; any mode with shamt 0 on 0x5A -> 0x5A, flag 0.
REQ-034 Back-to-back inputs A, B, C with out_ready held low -> in_ready falls after S1 and S2 fill; results stay stable; releasing out_ready returns A, B, C in order with none lost.
REQ-035 Assert rst_n low with both stages full -> out_valid is 0 on the next cycle; after release there is no stale result and in_ready = 1.
REQ-036 Random operands, modes and shamt, with randomised in_valid and out_ready -> every output matches the reference model; count in equals count out.
